// File: rtl/traffic_phase_timer_if.sv
// Signal bundle between the phase timer and its neighbours: timebase/pedestrian
// inputs toward the timer, phase indications and counter back out.
interface traffic_phase_timer_if #(
    parameter int unsigned CNT_W = 4
) ();
    logic             tick_en;
    logic             hold;
    logic             ped_req;
    logic             swap_tick;
    logic             side;
    logic             yellow;
    logic             all_red;
    logic             ped_ack;
    logic [CNT_W-1:0] remaining;

    // Drives the timebase and requests, observes the phase outputs.
    modport master (
        output tick_en, hold, ped_req,
        input  swap_tick, side, yellow, all_red, ped_ack, remaining
    );

    // The timer itself.
    modport slave (
        input  tick_en, hold, ped_req,
        output swap_tick, side, yellow, all_red, ped_ack, remaining
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// GREEN/YELLOW/ALLRED dwell sequencer feeding the two-direction light controller.
// Optional pedestrian green shortening is built when TRAFFIC_PED_SHORTEN_EN is defined.
module traffic_phase_timer #(
    parameter int unsigned GREEN_TICKS  = 8,
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned MIN_GREEN    = 3,
    parameter int unsigned CNT_W        = 4
) (
    input logic                  clk,
    input logic                  reset,
    traffic_phase_timer_if.slave bus
);

    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
    localparam logic [1:0] ST_ALLRED = 2'd2;

    // Counter load values: a phase of N ticks starts at N-1 and expires at 0.
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_LOAD    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_nx;
    logic             side;
    logic             side_nx;
    logic             swap_tick;
    logic             swap_tick_nx;
    logic             yellow;
    logic             yellow_nx;
    logic             all_red;
    logic             all_red_nx;
    logic             ped_ack;
    logic             ped_ack_nx;

    logic             en;
    logic             expire;
    logic             shorten;

    assign en     = bus.tick_en & ~bus.hold;
    assign expire = en && (remaining == '0);

`ifdef TRAFFIC_PED_SHORTEN_EN
    // A pending request only ever pulls the green end closer, never later.
    assign shorten = ped_ack && (remaining > MIN_LOAD);
`else
    logic unused_ped_req;
    assign unused_ped_req = bus.ped_req;
    assign shorten        = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        side_nx      = side;
        swap_tick_nx = 1'b0;
        ped_ack_nx   = ped_ack;

        case (state)
            ST_GREEN: begin
                if (expire) begin
                    state_nx     = ST_YELLOW;
                    remaining_nx = YELLOW_LOAD;
                end else if (en) begin
                    remaining_nx = shorten ? MIN_LOAD : (remaining - CNT_ONE);
                end
            end
            ST_YELLOW: begin
                if (expire) begin
                    state_nx     = ST_ALLRED;
                    remaining_nx = ALLRED_LOAD;
                end else if (en) begin
                    remaining_nx = remaining - CNT_ONE;
                end
            end
            ST_ALLRED: begin
                if (expire) begin
                    state_nx     = ST_GREEN;
                    remaining_nx = GREEN_LOAD;
                    side_nx      = ~side;
                    swap_tick_nx = 1'b1;
                end else if (en) begin
                    remaining_nx = remaining - CNT_ONE;
                end
            end
            default: begin
                state_nx     = ST_GREEN;
                remaining_nx = GREEN_LOAD;
            end
        endcase

        yellow_nx  = (state_nx == ST_YELLOW);
        all_red_nx = (state_nx == ST_ALLRED);

`ifdef TRAFFIC_PED_SHORTEN_EN
        // Green ending retires the request; a request on that same clock survives.
        if ((state == ST_GREEN) && expire) begin
            ped_ack_nx = 1'b0;
        end
        if (bus.ped_req) begin
            ped_ack_nx = 1'b1;
        end
`else
        ped_ack_nx = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_GREEN;
            remaining <= GREEN_LOAD;
            side      <= 1'b0;
            swap_tick <= 1'b0;
            yellow    <= 1'b0;
            all_red   <= 1'b0;
            ped_ack   <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            side      <= side_nx;
            swap_tick <= swap_tick_nx;
            yellow    <= yellow_nx;
            all_red   <= all_red_nx;
            ped_ack   <= ped_ack_nx;
        end
    end

    assign bus.remaining = remaining;
    assign bus.side      = side;
    assign bus.swap_tick = swap_tick;
    assign bus.yellow    = yellow;
    assign bus.all_red   = all_red;
    assign bus.ped_ack   = ped_ack;

endmodule
